// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: converts an OBI request/grant/rvalid port into single-outstanding
// Wishbone classic master cycles, with bus-error propagation and a timeout watchdog.
module obi_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WORD_ALIGN     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    timeout_o
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = (WORD_ALIGN != 0) ?
        ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1)) : {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic   wd_hit;

    assign obi_gnt_o = (state == IDLE) && obi_req_i;
    assign wb_stb_o  = wb_cyc_o;
    // The watchdog only fires when the slave stays silent in its final cycle.
    assign timeout_o = wd_hit && !wb_ack_i && !wb_err_i;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt <= '0;
                else if (obi_gnt_o)
                    cnt <= '0;
                else if (state == BUS)
                    cnt <= cnt + CW'(1);
            end
            assign wd_hit = (state == BUS) && (cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    obi_rvalid_o <= 1'b0;
                    if (obi_req_i) begin
                        state    <= BUS;
                        wb_cyc_o <= 1'b1;
                        wb_we_o  <= obi_we_i;
                        wb_sel_o <= obi_be_i;
                        wb_adr_o <= obi_addr_i & ALIGN_MASK;
                        wb_dat_o <= obi_wdata_i;
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || wd_hit) begin
                        state        <= RESP;
                        wb_cyc_o     <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        obi_err_o    <= wb_err_i || !wb_ack_i;
                        obi_rdata_o  <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    obi_rvalid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_obi_wb_bridge.sv
// tb_obi_wb_bridge: scenario tasks drive the bridge against a scripted Wishbone slave;
// expected responses are queued at grant time and checked whenever rvalid appears.
module tb_obi_wb_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        obi_req_i = 1'b0, obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_addr_i = '0, obi_wdata_i = '0, wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic        obi_gnt_o, obi_rvalid_o, obi_err_o, timeout_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] obi_rdata_o, wb_adr_o, wb_dat_o;
    logic [70:0] bus;

    typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;
    rsp_t exp_q[$];
    rsp_t e;
    int checks = 0;
    int errors = 0;

    obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .WORD_ALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i),
        .obi_addr_i(obi_addr_i), .obi_wdata_i(obi_wdata_i), .obi_rvalid_o(obi_rvalid_o),
        .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    assign bus = {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o};

    // Response scoreboard
    always @(negedge clk) begin
        if (rst_n && obi_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b, required no response", obi_rdata_o, obi_err_o);
            end else begin
                e = exp_q.pop_front();
                if ({obi_rdata_o, obi_err_o} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL rsp_data got rdata=%h err=%b, required rdata=%h err=%b",
                             obi_rdata_o, obi_err_o, e.rdata, e.err);
                end
            end
        end
    end

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_i = 1'b1; obi_we_i = we; obi_be_i = be; obi_addr_i = addr; obi_wdata_i = wdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, bus, timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h err=%b bus=%h to=%b, required all 0",
                     obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, bus, timeout_o);
        end
        next; next;
        rst_n = 1'b1;
    endtask

    task automatic test_read_comb;
        next; issue(1'b0, 4'hF, 32'h104, 32'h0);
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'hDEADBEEF, 1'b0});
        next; obi_req_i = 1'b0; wb_dat_i = 32'hDEADBEEF; wb_ack_i = 1'b1;
        @(negedge clk); checks++;
        if ({obi_gnt_o, bus} !== {1'b0, 3'b110, 4'hF, 32'h104, 32'h0}) begin
            errors++; $display("FAIL rd_bus got gnt=%b bus=%h", obi_gnt_o, bus);
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if ({obi_rvalid_o, wb_cyc_o} !== 2'b10) begin
            errors++; $display("FAIL rd_rvalid_time got rvalid=%b cyc=%b required 1 0", obi_rvalid_o, wb_cyc_o);
        end
        next;
    endtask

    task automatic test_write_delayed;
        next; issue(1'b1, 4'h3, 32'h200, 32'h12345678);
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h0, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            next; obi_req_i = 1'b0; wb_ack_i = (k == 4);
            @(negedge clk); checks++;
            if ({obi_gnt_o, obi_rvalid_o, bus} !== {2'b00, 3'b111, 4'h3, 32'h200, 32'h12345678}) begin
                errors++; $display("FAIL wr_hold cycle %0d got gnt=%b rvalid=%b bus=%h", k, obi_gnt_o, obi_rvalid_o, bus);
            end
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if ({obi_rvalid_o, wb_cyc_o} !== 2'b10) begin
            errors++; $display("FAIL wr_rvalid_time got rvalid=%b cyc=%b required 1 0", obi_rvalid_o, wb_cyc_o);
        end
        next;
    endtask

    task automatic test_bus_error;
        next; issue(1'b0, 4'hF, 32'h300, 32'h0);
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL err_gnt got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h0, 1'b1});
        next; obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        next; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk); checks++;
        if ({obi_rvalid_o, wb_cyc_o, timeout_o} !== 3'b100) begin
            errors++; $display("FAIL err_rvalid got rvalid=%b cyc=%b to=%b required 1 0 0", obi_rvalid_o, wb_cyc_o, timeout_o);
        end
        next;
    endtask

    task automatic test_watchdog;
        next; issue(1'b0, 4'hF, 32'h400, 32'h0);
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL wd_gnt got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h0, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            next; obi_req_i = 1'b0;
            @(negedge clk); checks++;
            if ({wb_cyc_o, timeout_o, obi_rvalid_o} !== {1'b1, k == 8, 1'b0}) begin
                errors++; $display("FAIL wd_cycle %0d got cyc=%b to=%b rvalid=%b", k, wb_cyc_o, timeout_o, obi_rvalid_o);
            end
        end
        next;
        @(negedge clk); checks++;
        if ({wb_cyc_o, timeout_o, obi_rvalid_o} !== 3'b001) begin
            errors++; $display("FAIL wd_resp got cyc=%b to=%b rvalid=%b required 0 0 1", wb_cyc_o, timeout_o, obi_rvalid_o);
        end
        // Ack in the watchdog's final cycle completes normally.
        next; issue(1'b0, 4'hF, 32'h404, 32'h0); wb_dat_i = 32'hCAFEF00D;
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL wd_regrant got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'hCAFEF00D, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            next; obi_req_i = 1'b0; wb_ack_i = (k == 8);
            @(negedge clk); checks++;
            if ({wb_cyc_o, timeout_o, obi_rvalid_o} !== 3'b100) begin
                errors++; $display("FAIL wd_late_ack cycle %0d got cyc=%b to=%b rvalid=%b", k, wb_cyc_o, timeout_o, obi_rvalid_o);
            end
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if ({wb_cyc_o, timeout_o, obi_rvalid_o} !== 3'b001) begin
            errors++; $display("FAIL wd_late_resp got cyc=%b to=%b rvalid=%b required 0 0 1", wb_cyc_o, timeout_o, obi_rvalid_o);
        end
        next;
    endtask

    task automatic test_back_to_back;
        next; issue(1'b1, 4'hF, 32'h500, 32'hAAAA5555);
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h0, 1'b0});
        next; issue(1'b1, 4'hC, 32'h504, 32'h5555AAAA); wb_ack_i = 1'b1;
        @(negedge clk); checks++;
        if ({obi_gnt_o, bus} !== {1'b0, 3'b111, 4'hF, 32'h500, 32'hAAAA5555}) begin
            errors++; $display("FAIL b2b_bus1 got gnt=%b bus=%h", obi_gnt_o, bus);
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if ({obi_gnt_o, obi_rvalid_o} !== 2'b01) begin
            errors++; $display("FAIL b2b_resp1 got gnt=%b rvalid=%b required 0 1", obi_gnt_o, obi_rvalid_o);
        end
        next;
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt2 got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h0, 1'b0});
        next; obi_req_i = 1'b0; wb_ack_i = 1'b1;
        @(negedge clk); checks++;
        if ({obi_gnt_o, bus} !== {1'b0, 3'b111, 4'hC, 32'h504, 32'h5555AAAA}) begin
            errors++; $display("FAIL b2b_bus2 got gnt=%b bus=%h", obi_gnt_o, bus);
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if ({obi_gnt_o, obi_rvalid_o} !== 2'b01) begin
            errors++; $display("FAIL b2b_resp2 got gnt=%b rvalid=%b required 0 1", obi_gnt_o, obi_rvalid_o);
        end
        next;
    endtask

    task automatic test_stray_ack;
        next; wb_ack_i = 1'b1; wb_err_i = 1'b1;
        next; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk); checks++;
        if ({wb_cyc_o, obi_rvalid_o, timeout_o} !== 3'b000) begin
            errors++; $display("FAIL stray_ack got cyc=%b rvalid=%b to=%b required 0 0 0", wb_cyc_o, obi_rvalid_o, timeout_o);
        end
    endtask

    task automatic test_reset_mid_bus;
        next; issue(1'b0, 4'hF, 32'h600, 32'h0);
        next; obi_req_i = 1'b0;
        @(negedge clk); checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_pre_cyc got %b required 1", wb_cyc_o); end
        #2 rst_n = 1'b0;
        #1; checks++;
        if ({wb_cyc_o, wb_stb_o, obi_rvalid_o} !== 3'b000) begin
            errors++; $display("FAIL rst_async_drop got cyc=%b stb=%b rvalid=%b required 0", wb_cyc_o, wb_stb_o, obi_rvalid_o);
        end
        next; next; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next;
            @(negedge clk); checks++;
            if ({wb_cyc_o, obi_rvalid_o, obi_gnt_o} !== 3'b000) begin
                errors++; $display("FAIL rst_after cycle %0d got cyc=%b rvalid=%b gnt=%b", k, wb_cyc_o, obi_rvalid_o, obi_gnt_o);
            end
        end
        // Unaligned address after reset: low bits must be cleared on the bus.
        next; issue(1'b0, 4'h2, 32'h60B, 32'h0); wb_dat_i = 32'h11112222;
        @(negedge clk); checks++;
        if (obi_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_idle_gnt got %b required 1", obi_gnt_o); end
        exp_q.push_back('{32'h11112222, 1'b0});
        next; obi_req_i = 1'b0; wb_ack_i = 1'b1;
        @(negedge clk); checks++;
        if ({wb_adr_o, wb_sel_o} !== {32'h608, 4'h2}) begin
            errors++; $display("FAIL align_adr got adr=%h sel=%h required 00000608 2", wb_adr_o, wb_sel_o);
        end
        next; wb_ack_i = 1'b0;
        @(negedge clk); checks++;
        if (obi_rvalid_o !== 1'b1) begin errors++; $display("FAIL rst_resp got rvalid=%b required 1", obi_rvalid_o); end
        next;
    endtask

    initial begin
        test_reset();
        test_read_comb();
        test_write_delayed();
        test_bus_error();
        test_watchdog();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid_bus();
        next; next;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rsp_missing got %0d outstanding required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
